pipe_mem_wb: RTL and testbench
==============================

# pipe_mem_wb

Memory-access and write-back stage of the pipelined `sccpu`, sitting directly downstream of the EX/MEM register. It holds the data RAM, performs loads and stores for the instruction in the M stage, and registers the results into the MEM/WB pipeline register. It also produces the final write-back value and destination for the register file, and exports those W-stage values for forwarding.

## Interface
Parameters:
- `ADDR_BITS`, 5, log2 of data RAM depth in 32-bit words (default 32 words)

Ports:
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `mwreg`  in  1  M-stage instruction writes a register
- `mm2reg`  in  1  M-stage instruction is a load (write-back from memory)
- `mwmem`  in  1  M-stage instruction is a store
- `mrn`  in  5  M-stage destination register number
- `mresult`  in  32  M-stage ALU result; byte address for loads/stores
- `mqb`  in  32  M-stage store data
- `mram_data`  out  32  combinational RAM read data at `mresult`
- `mfault`  out  1  combinational: M-stage access misaligned
- `wwreg`  out  1  W-stage register write enable (to register file)
- `wrn`  out  5  W-stage destination register number
- `wdi`  out  32  W-stage write-back data
- `wfault`  out  1  registered misalignment flag of the W-stage instruction

## Operation
- Word index = `mresult[ADDR_BITS+1:2]`; upper address bits ignored (address wraps modulo 4·2^ADDR_BITS bytes).
- `mfault` = (`mwmem` | `mm2reg`) & (`mresult[1:0]` != 0).
- `mram_data` = RAM[word index], asynchronous read, independent of `mm2reg`.
- Store: at rising edge, if `mwmem` & !`mfault`, RAM[word index] <= `mqb`. Misaligned stores write nothing.
- MEM/WB register captures each edge: `wm2reg_r`<=`mm2reg`, `wrn`<=`mrn`, `wmo_r`<=`mram_data`, `walu_r`<=`mresult`, `wfault`<=`mfault`.
- `wwreg` register <= `mwreg` & !`mfault` (misaligned loads are squashed: no register write).
- `wdi` = `wm2reg_r` ? `wmo_r` : `walu_r` (combinational from W registers).
- Register number 0: `wwreg` still asserted if requested; register file discards writes to r0. This stage does no filtering.
- Simultaneous `mwmem` and `mm2reg`: store performed; read data is the pre-store value; W captures old value.
- No stall input: pipeline advances every cycle; bubbles arrive as all control inputs 0.

## Timing
- Reset (async, immediate): `wwreg`=0, `wrn`=0, `wdi`=0, `wfault`=0, internal `wm2reg_r`/`wmo_r`/`walu_r`=0, all RAM words=0. `mram_data` then reads 0; `mfault` follows inputs.
- Reset asserted mid-operation: any store whose edge coincides with reset is lost; RAM is zeroed.
- First rising edge after reset release loads MEM/WB normally.
- Load latency: M-stage address at cycle n → `wdi` valid after edge n+1 (one-cycle stage latency).
- Store then load, same word, back-to-back (store in M at n, load in M at n+1): load sees stored data (write at edge ending n, async read during n+1). No internal bypass needed.
- Store and load in same cycle impossible (single M slot) except the simultaneous case above.
- `mram_data`, `mfault` are purely combinational from M inputs and RAM state.

## Test plan
- Reset: hold `reset`=1 with random inputs, toggle `clock` → `wwreg`=0, `wrn`=0, `wdi`=0, `wfault`=0; `mresult`=0x40 reads `mram_data`=0.
- ALU write-back: `mwreg`=1, `mm2reg`=0, `mrn`=5, `mresult`=0x1234_5678 → after one edge `wwreg`=1, `wrn`=5, `wdi`=0x1234_5678.
- Store/load back-to-back: store `mresult`=0x8, `mqb`=0xDEAD_BEEF; next cycle load `mresult`=0x8, `mrn`=3 → `mram_data`=0xDEAD_BEEF during load cycle; `wdi`=0xDEAD_BEEF, `wrn`=3 one edge later.
- Address wrap (`ADDR_BITS`=5): store 0xA5A5_A5A5 at 0x84 → load from 0x04 returns 0xA5A5_A5A5.
- Misaligned: store 0x1111_1111 at 0x0A → `mfault`=1, RAM word 2 unchanged (load 0x08 returns prior value); misaligned load with `mwreg`=1 → `wwreg`=0, `wfault`=1.
- Async reset mid-stream: store 0x55 to 0x10, then assert `reset` between edges → outputs 0 immediately; after release, load 0x10 returns 0.

Source files
------------

// File: rtl/pipe_mem_wb.sv
// ---------------------------------------------------------------------------
// pipe_mem_wb
//
// Memory-access and write-back stage of the pipelined sccpu. It sits
// directly downstream of the EX/MEM register and does four things:
//   - holds the word-organised data RAM,
//   - performs the load or store of the instruction in the M stage,
//   - registers the stage results into the MEM/WB pipeline register,
//   - produces the final write-back value and destination for the
//     register file, which also feed the forwarding network.
//
// Parameters
//   ADDR_BITS : log2 of the data RAM depth in 32-bit words.
//
// Ports
//   clock     in   system clock; all state updates on the rising edge
//   reset     in   asynchronous, active-high; clears all state and the RAM
//   mwreg     in   M-stage instruction writes a register
//   mm2reg    in   M-stage instruction is a load
//   mwmem     in   M-stage instruction is a store
//   mrn       in   M-stage destination register number
//   mresult   in   M-stage ALU result; byte address for loads and stores
//   mqb       in   M-stage store data
//   mram_data out  combinational RAM read data at mresult
//   mfault    out  combinational M-stage misalignment flag
//   wwreg     out  W-stage register write enable
//   wrn       out  W-stage destination register number
//   wdi       out  W-stage write-back data
//   wfault    out  registered misalignment flag of the W-stage instruction
// ---------------------------------------------------------------------------
module pipe_mem_wb #(
    parameter int ADDR_BITS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [4:0]  mrn,
    input  logic [31:0] mresult,
    input  logic [31:0] mqb,
    output logic [31:0] mram_data,
    output logic        mfault,
    output logic        wwreg,
    output logic [4:0]  wrn,
    output logic [31:0] wdi,
    output logic        wfault
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // A memory access is misaligned when either of the two byte-offset bits
    // is set; non-memory instructions never fault.
    function automatic logic misaligned(input logic        is_mem,
                                        input logic [1:0]  byte_off);
        misaligned = is_mem & (byte_off != 2'b00);
    endfunction

    // Data RAM; reset clears every word, so it is built from flops.
    logic [31:0]          ram_q [DEPTH];

    // M-stage decode
    logic [ADDR_BITS-1:0] word_idx_s;
    logic                 fault_s;
    logic                 ram_we_s;

    // MEM/WB pipeline register
    logic                 wwreg_d,  wwreg_q;
    logic                 wm2reg_d, wm2reg_q;
    logic [4:0]           wrn_d,    wrn_q;
    logic [31:0]          wmo_d,    wmo_q;
    logic [31:0]          walu_d,   walu_q;
    logic                 wfault_d, wfault_q;

    // M-stage address decode, fault detection, store enable and RAM read.
    // Upper address bits are dropped so the address space wraps onto the RAM.
    always_comb begin
        word_idx_s = mresult[ADDR_BITS+1:2];
        fault_s    = misaligned(mwmem | mm2reg, mresult[1:0]);
        if (mwmem && !fault_s) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
        // Read is independent of mm2reg and sees the pre-store contents.
        mram_data = ram_q[word_idx_s];
        mfault    = fault_s;
    end

    // Data RAM write port; asynchronous reset zeroes the whole array, which
    // also discards any store whose edge coincides with reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= 32'h0000_0000;
            end
        end else if (ram_we_s) begin
            ram_q[word_idx_s] <= mqb;
        end
    end

    // Next-state values for the MEM/WB register. A misaligned instruction
    // loses its register write so a faulting load cannot corrupt the file.
    always_comb begin
        wwreg_d  = mwreg & ~fault_s;
        wm2reg_d = mm2reg;
        wrn_d    = mrn;
        wmo_d    = mram_data;
        walu_d   = mresult;
        wfault_d = fault_s;
    end

    // MEM/WB pipeline register; advances every cycle (no stall).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wrn_q    <= 5'd0;
            wmo_q    <= 32'h0000_0000;
            walu_q   <= 32'h0000_0000;
            wfault_q <= 1'b0;
        end else begin
            wwreg_q  <= wwreg_d;
            wm2reg_q <= wm2reg_d;
            wrn_q    <= wrn_d;
            wmo_q    <= wmo_d;
            walu_q   <= walu_d;
            wfault_q <= wfault_d;
        end
    end

    // W-stage outputs. Register 0 is not filtered here; the register file
    // discards writes to r0 itself.
    always_comb begin
        wwreg  = wwreg_q;
        wrn    = wrn_q;
        wfault = wfault_q;
        if (wm2reg_q) begin
            wdi = wmo_q;
        end else begin
            wdi = walu_q;
        end
    end

endmodule

// File: tb/tb_pipe_mem_wb.sv
module tb_pipe_mem_wb;

    logic        clock;
    logic        reset;
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [4:0]  mrn;
    logic [31:0] mresult;
    logic [31:0] mqb;
    logic [31:0] mram_data;
    logic        mfault;
    logic        wwreg;
    logic [4:0]  wrn;
    logic [31:0] wdi;
    logic        wfault;

    int n_cmp;
    int n_err;

    pipe_mem_wb #(.ADDR_BITS(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .mrn       (mrn),
        .mresult   (mresult),
        .mqb       (mqb),
        .mram_data (mram_data),
        .mfault    (mfault),
        .wwreg     (wwreg),
        .wrn       (wrn),
        .wdi       (wdi),
        .wfault    (wfault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        mwreg;
        logic        mm2reg;
        logic        mwmem;
        logic [4:0]  mrn;
        logic [31:0] mresult;
        logic [31:0] mqb;
        logic [31:0] exp_mram;
        logic        exp_mfault;
        logic        exp_wwreg;
        logic [4:0]  exp_wrn;
        logic [31:0] exp_wdi;
        logic        exp_wfault;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic l, input logic s,
                         input logic [4:0] rn, input logic [31:0] res, input logic [31:0] qb);
        mwreg   = w;
        mm2reg  = l;
        mwmem   = s;
        mrn     = rn;
        mresult = res;
        mqb     = qb;
    endtask

    // Apply one vector: check M-stage combinational outputs before the edge,
    // then the MEM/WB outputs just after it.
    task automatic apply(input vec_t v);
        drive(v.mwreg, v.mm2reg, v.mwmem, v.mrn, v.mresult, v.mqb);
        #1;
        chk({v.name, ".mram_data"}, mram_data, v.exp_mram);
        chk({v.name, ".mfault"}, {31'd0, mfault}, {31'd0, v.exp_mfault});
        @(posedge clock);
        #1;
        chk({v.name, ".wwreg"}, {31'd0, wwreg}, {31'd0, v.exp_wwreg});
        chk({v.name, ".wrn"}, {27'd0, wrn}, {27'd0, v.exp_wrn});
        chk({v.name, ".wdi"}, wdi, v.exp_wdi);
        chk({v.name, ".wfault"}, {31'd0, wfault}, {31'd0, v.exp_wfault});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //          name        wreg  m2r   wmem  rn     mresult        mqb            exp_mram       flt   wwreg rn     wdi            wflt
        vecs[0]  = '{"alu_wb",   1'b1, 1'b0, 1'b0, 5'd5,  32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 5'd5,  32'h1234_5678, 1'b0};
        vecs[1]  = '{"st_8",     1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0000_0008, 1'b0};
        vecs[2]  = '{"ld_8",     1'b1, 1'b1, 1'b0, 5'd3,  32'h0000_0008, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{"st_84",    1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_0084, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0000_0084, 1'b0};
        vecs[4]  = '{"ld_wrap",  1'b1, 1'b1, 1'b0, 5'd7,  32'h0000_0004, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 1'b1, 5'd7,  32'hA5A5_A5A5, 1'b0};
        vecs[5]  = '{"st_mis",   1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_000A, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0,  32'h0000_000A, 1'b1};
        vecs[6]  = '{"ld_8_chk", 1'b1, 1'b1, 1'b0, 5'd4,  32'h0000_0008, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd4,  32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{"ld_mis",   1'b1, 1'b1, 1'b0, 5'd9,  32'h0000_0009, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd9,  32'hDEAD_BEEF, 1'b1};
        vecs[8]  = '{"st_ld_sim",1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_0084, 32'h0BAD_F00D, 32'hA5A5_A5A5, 1'b0, 1'b1, 5'd10, 32'hA5A5_A5A5, 1'b0};
        vecs[9]  = '{"ld_after", 1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_0004, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 1'b1, 5'd11, 32'h0BAD_F00D, 1'b0};
        vecs[10] = '{"alu_r0",   1'b1, 1'b0, 1'b0, 5'd0,  32'hFFFF_FFF3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 5'd0,  32'hFFFF_FFF3, 1'b0};
        vecs[11] = '{"alu_odd",  1'b1, 1'b0, 1'b0, 5'd31, 32'h0000_000B, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd31, 32'h0000_000B, 1'b0};
        vecs[12] = '{"bubble",   1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0};

        // Reset held with random inputs: stores must be ignored, W cleared.
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
            @(posedge clock);
            #1;
        end
        chk("rst.wwreg", {31'd0, wwreg}, 32'd0);
        chk("rst.wrn", {27'd0, wrn}, 32'd0);
        chk("rst.wdi", wdi, 32'd0);
        chk("rst.wfault", {31'd0, wfault}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0040, 32'h0000_0000);
        #1;
        chk("rst.mram_40", mram_data, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0000, 32'h0000_0000);
        #2;
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
        end

        // Async reset mid-stream: store 0x55 to 0x10, load it back, then
        // assert reset between edges.
        apply('{"st_10", 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0010, 32'h0000_0055,
                32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'h0000_0010, 1'b0});
        apply('{"ld_10", 1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_0010, 32'h0000_0000,
                32'h0000_0055, 1'b0, 1'b1, 5'd6, 32'h0000_0055, 1'b0});
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0010, 32'h0000_0000);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.wwreg", {31'd0, wwreg}, 32'd0);
        chk("arst.wrn", {27'd0, wrn}, 32'd0);
        chk("arst.wdi", wdi, 32'd0);
        chk("arst.mram_10", mram_data, 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        apply('{"ld_10_post", 1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_0010, 32'h0000_0000,
                32'h0000_0000, 1'b0, 1'b1, 5'd6, 32'h0000_0000, 1'b0});
        apply('{"ld_8_post", 1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0008, 32'h0000_0000,
                32'h0000_0000, 1'b0, 1'b1, 5'd2, 32'h0000_0000, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
